// File: rtl/stopwatch_control.sv
// MM:SS stopwatch controller: synchronized/debounced controls, PAUSE/RUN/ADJ mode FSM
// and a BCD time register counting on the 1 Hz strobe or adjusting one field at a time.
module stopwatch_control #(
    parameter int unsigned DEB_SAMPLES = 3
) (
    input  logic       M_CLK,
    input  logic       RST_N,
    input  logic       ONE_TICK,
    input  logic       ADJ_TICK,
    input  logic       FAST_TICK,
    input  logic       BTN_PAUSE,
    input  logic       BTN_RESET,
    input  logic       SW_ADJ,
    input  logic       SW_SEL,
    output logic [3:0] MIN_TENS,
    output logic [3:0] MIN_ONES,
    output logic [3:0] SEC_TENS,
    output logic [3:0] SEC_ONES,
    output logic       RUNNING,
    output logic       ADJUSTING
);

    localparam int unsigned   CNT_W    = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_SAMPLES - 1);

    // Bit positions within the synchronizer vectors
    localparam int unsigned IDX_PAUSE = 0;
    localparam int unsigned IDX_CLEAR = 1;
    localparam int unsigned IDX_ADJ   = 2;
    localparam int unsigned IDX_SEL   = 3;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_ADJ   = 2'd2
    } state_t;

    logic [3:0]            sync1_q, sync1_d;
    logic [3:0]            sync2_q, sync2_d;
    logic [1:0]            deb_lvl_q, deb_lvl_d;
    logic [1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]            evt_q, evt_d;
    state_t                state_q, state_d;
    logic [3:0]            min_tens_q, min_tens_d;
    logic [3:0]            min_ones_q, min_ones_d;
    logic [3:0]            sec_tens_q, sec_tens_d;
    logic [3:0]            sec_ones_q, sec_ones_d;

    logic       pause_evt;
    logic       clear_evt;
    logic       sw_adj_s;
    logic       sw_sel_s;
    logic [8:0] sec_inc;
    logic [8:0] min_inc;

    // Advance a 00..59 BCD field; result is {carry, tens, ones}.
    function automatic logic [8:0] inc_field(input logic [3:0] tens, input logic [3:0] ones);
        logic [8:0] res;
        if (ones >= 4'd9) begin
            if (tens >= 4'd5) begin
                res = {1'b1, 4'd0, 4'd0};
            end else begin
                res = {1'b0, tens + 4'd1, 4'd0};
            end
        end else begin
            res = {1'b0, tens, ones + 4'd1};
        end
        return res;
    endfunction

    always_comb begin
        sync1_d = {SW_SEL, SW_ADJ, BTN_RESET, BTN_PAUSE};
        sync2_d = sync1_q;
    end

    assign sw_adj_s  = sync2_q[IDX_ADJ];
    assign sw_sel_s  = sync2_q[IDX_SEL];
    assign pause_evt = evt_q[IDX_PAUSE];
    assign clear_evt = evt_q[IDX_CLEAR];

    // Counter holds the run length of samples disagreeing with the accepted level.
    always_comb begin
        deb_lvl_d = deb_lvl_q;
        deb_cnt_d = deb_cnt_q;
        evt_d     = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (FAST_TICK) begin
                if (sync2_q[i] == deb_lvl_q[i]) begin
                    deb_cnt_d[i] = '0;
                end else if (deb_cnt_q[i] == CNT_LAST) begin
                    deb_lvl_d[i] = sync2_q[i];
                    deb_cnt_d[i] = '0;
                    evt_d[i]     = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw_adj_s) begin
            state_d = ST_ADJ;
        end else begin
            case (state_q)
                ST_PAUSE: begin
                    if (!clear_evt && pause_evt) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clear_evt || pause_evt) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_ADJ:  state_d = ST_PAUSE;
                default: state_d = ST_PAUSE;
            endcase
        end
    end

    always_comb begin
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        sec_inc    = inc_field(sec_tens_q, sec_ones_q);
        min_inc    = inc_field(min_tens_q, min_ones_q);
        if (clear_evt) begin
            min_tens_d = '0;
            min_ones_d = '0;
            sec_tens_d = '0;
            sec_ones_d = '0;
        end else if (state_q == ST_RUN && ONE_TICK) begin
            {sec_tens_d, sec_ones_d} = sec_inc[7:0];
            if (sec_inc[8]) begin
                {min_tens_d, min_ones_d} = min_inc[7:0];
            end
        end else if (state_q == ST_ADJ && ADJ_TICK) begin
            // Adjust wraps within the selected field only; carry is dropped.
            if (sw_sel_s) begin
                {sec_tens_d, sec_ones_d} = sec_inc[7:0];
            end else begin
                {min_tens_d, min_ones_d} = min_inc[7:0];
            end
        end
    end

    always_ff @(posedge M_CLK) begin
        if (!RST_N) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_lvl_q  <= '0;
            deb_cnt_q  <= '0;
            evt_q      <= '0;
            state_q    <= ST_PAUSE;
            min_tens_q <= '0;
            min_ones_q <= '0;
            sec_tens_q <= '0;
            sec_ones_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_lvl_q  <= deb_lvl_d;
            deb_cnt_q  <= deb_cnt_d;
            evt_q      <= evt_d;
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
        end
    end

    assign MIN_TENS  = min_tens_q;
    assign MIN_ONES  = min_ones_q;
    assign SEC_TENS  = sec_tens_q;
    assign SEC_ONES  = sec_ones_q;
    assign RUNNING   = (state_q == ST_RUN);
    assign ADJUSTING = (state_q == ST_ADJ);

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: directed vector table, corner-case sequences, then
// random stimulus against a cycle-level behavioural model.
module tb_stopwatch_control;

    localparam int DEB = 3;

    logic       M_CLK;
    logic       RST_N;
    logic       ONE_TICK, ADJ_TICK, FAST_TICK;
    logic       BTN_PAUSE, BTN_RESET, SW_ADJ, SW_SEL;
    logic [3:0] MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES;
    logic       RUNNING, ADJUSTING;

    int total = 0;
    int bad   = 0;

    stopwatch_control #(.DEB_SAMPLES(DEB)) dut (
        .M_CLK     (M_CLK),
        .RST_N     (RST_N),
        .ONE_TICK  (ONE_TICK),
        .ADJ_TICK  (ADJ_TICK),
        .FAST_TICK (FAST_TICK),
        .BTN_PAUSE (BTN_PAUSE),
        .BTN_RESET (BTN_RESET),
        .SW_ADJ    (SW_ADJ),
        .SW_SEL    (SW_SEL),
        .MIN_TENS  (MIN_TENS),
        .MIN_ONES  (MIN_ONES),
        .SEC_TENS  (SEC_TENS),
        .SEC_ONES  (SEC_ONES),
        .RUNNING   (RUNNING),
        .ADJUSTING (ADJUSTING)
    );

    initial M_CLK = 1'b0;
    always #5 M_CLK = ~M_CLK;

    // Behavioural model: time held as integer minutes/seconds, mode 0=pause 1=run 2=adjust,
    // debounce as a streak of identical samples.
    int         m_min, m_sec, m_mode;
    logic [3:0] m_dly0, m_dly1;
    logic       m_last[2];
    int         m_streak[2];
    logic       m_lvl[2];
    logic       m_evt[2];

    task automatic model_edge();
        logic [3:0] syn;
        int         nmode;
        if (!RST_N) begin
            m_min = 0; m_sec = 0; m_mode = 0;
            m_dly0 = '0; m_dly1 = '0;
            for (int b = 0; b < 2; b++) begin
                m_last[b] = 1'b0; m_streak[b] = 0; m_lvl[b] = 1'b0; m_evt[b] = 1'b0;
            end
            return;
        end
        syn = m_dly1;
        if (m_evt[1]) begin
            m_min = 0; m_sec = 0;
        end else if (m_mode == 1 && ONE_TICK) begin
            m_sec = m_sec + 1;
            if (m_sec == 60) begin
                m_sec = 0;
                m_min = (m_min + 1) % 60;
            end
        end else if (m_mode == 2 && ADJ_TICK) begin
            if (syn[3]) m_sec = (m_sec + 1) % 60;
            else        m_min = (m_min + 1) % 60;
        end
        nmode = m_mode;
        if (syn[2])             nmode = 2;
        else if (m_mode == 2)   nmode = 0;
        else if (m_evt[1])      nmode = 0;
        else if (m_evt[0])      nmode = (m_mode == 0) ? 1 : 0;
        for (int b = 0; b < 2; b++) begin
            m_evt[b] = 1'b0;
            if (FAST_TICK) begin
                if (syn[b] == m_last[b]) begin
                    m_streak[b] = m_streak[b] + 1;
                end else begin
                    m_last[b]   = syn[b];
                    m_streak[b] = 1;
                end
                if (m_streak[b] >= DEB && m_last[b] != m_lvl[b]) begin
                    m_lvl[b] = m_last[b];
                    m_evt[b] = m_last[b];
                end
            end
        end
        m_dly1 = m_dly0;
        m_dly0 = {SW_SEL, SW_ADJ, BTN_RESET, BTN_PAUSE};
        m_mode = nmode;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge M_CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input int mn, input int sc,
                            input logic run, input logic adj);
        logic [15:0] exp_t;
        exp_t = {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
        chk({name, "_time"}, {16'd0, MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES}, {16'd0, exp_t});
        chk({name, "_mode"}, {30'd0, RUNNING, ADJUSTING}, {30'd0, run, adj});
    endtask

    task automatic drive(input logic rst, input logic bp, input logic br, input logic sa,
                         input logic ss, input logic one, input logic adj, input logic fast);
        RST_N = rst; BTN_PAUSE = bp; BTN_RESET = br; SW_ADJ = sa;
        SW_SEL = ss; ONE_TICK = one; ADJ_TICK = adj; FAST_TICK = fast;
    endtask

    typedef struct {
        logic rst, bp, br, sa, ss, one, adj, fast;
        int   n;
        int   emin, esec;
        logic erun, eadj;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic bp, input logic br, input logic sa,
                                input logic ss, input logic one, input logic adj, input logic fast,
                                input int n, input int emin, input int esec,
                                input logic erun, input logic eadj);
        vec_t v;
        v.rst = rst; v.bp = bp; v.br = br; v.sa = sa; v.ss = ss;
        v.one = one; v.adj = adj; v.fast = fast; v.n = n;
        v.emin = emin; v.esec = esec; v.erun = erun; v.eadj = eadj;
        return v;
    endfunction

    vec_t vt[18];

    initial begin
        //            rst bp br sa ss one adj fst  n   min sec run adj
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  2,  0,  0, 0, 0);
        vt[1]  = mk(1, 1, 0, 0, 0, 0, 0, 1,  6,  0,  0, 1, 0);
        vt[2]  = mk(1, 0, 0, 0, 0, 0, 0, 1,  6,  0,  0, 1, 0);
        vt[3]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 61,  1,  1, 1, 0);
        vt[4]  = mk(1, 1, 0, 0, 0, 0, 0, 0,  5,  1,  1, 1, 0);
        vt[5]  = mk(1, 1, 0, 0, 0, 0, 0, 1,  1,  1,  1, 1, 0);
        vt[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  3,  1,  1, 1, 0);
        vt[7]  = mk(1, 0, 0, 0, 0, 0, 0, 1,  3,  1,  1, 1, 0);
        vt[8]  = mk(1, 1, 0, 0, 0, 0, 0, 1,  6,  1,  1, 0, 0);
        vt[9]  = mk(1, 0, 0, 0, 0, 0, 0, 1,  6,  1,  1, 0, 0);
        vt[10] = mk(1, 0, 0, 0, 0, 1, 0, 0, 10,  1,  1, 0, 0);
        vt[11] = mk(1, 0, 0, 1, 1, 0, 1, 0, 61,  1, 59, 0, 1);
        vt[12] = mk(1, 0, 0, 1, 0, 0, 0, 0,  3,  1, 59, 0, 1);
        vt[13] = mk(1, 0, 0, 1, 0, 0, 1, 0, 58, 59, 59, 0, 1);
        vt[14] = mk(1, 0, 0, 0, 0, 0, 0, 0,  3, 59, 59, 0, 0);
        vt[15] = mk(1, 1, 0, 0, 0, 0, 0, 1,  6, 59, 59, 1, 0);
        vt[16] = mk(1, 0, 0, 0, 0, 0, 0, 1,  6, 59, 59, 1, 0);
        vt[17] = mk(1, 0, 0, 0, 0, 1, 0, 0,  1,  0,  0, 1, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].rst, vt[i].bp, vt[i].br, vt[i].sa, vt[i].ss,
                  vt[i].one, vt[i].adj, vt[i].fast);
            for (int k = 0; k < vt[i].n; k++) cyc();
            chk_time($sformatf("vec%0d", i), vt[i].emin, vt[i].esec, vt[i].erun, vt[i].eadj);
        end

        // Clear press landing on the same cycle as a ONE_TICK while running at 12:34
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 754; k++) cyc();
        chk_time("run_1234", 12, 34, 1, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) cyc();
        chk_time("clr_pending", 12, 34, 1, 0);
        drive(1, 0, 1, 0, 0, 1, 0, 1);
        cyc();
        chk_time("clr_vs_tick", 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) cyc();
        chk_time("clr_release", 0, 0, 0, 0);

        // Reset pulse while running at 07:15
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) cyc();
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 6; k++) cyc();
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 435; k++) cyc();
        chk_time("run_0715", 7, 15, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        cyc();
        chk_time("rst_pulse", 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 0);
        cyc();
        chk_time("post_rst_tick", 0, 0, 0, 0);

        // Seconds-field adjust wrapping 58 -> 01 with ONE_TICKs interleaved
        drive(1, 0, 0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc();
        chk_time("adj_enter", 0, 0, 0, 1);
        drive(1, 0, 0, 1, 1, 0, 1, 0);
        for (int k = 0; k < 58; k++) cyc();
        chk_time("adj_0058", 0, 58, 0, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 1, 1, 0, 1, 0);
            cyc();
            drive(1, 0, 0, 1, 1, 1, 0, 0);
            cyc();
        end
        chk_time("adj_wrap", 0, 1, 0, 1);
        drive(1, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc();
        chk_time("adj_exit", 0, 1, 0, 0);

        // Random stimulus against the model
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        for (int k = 0; k < 4000; k++) begin
            RST_N     = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 11) == 0) BTN_PAUSE = ~BTN_PAUSE;
            if ($urandom_range(0, 23) == 0) BTN_RESET = ~BTN_RESET;
            if ($urandom_range(0, 79) == 0) SW_ADJ    = ~SW_ADJ;
            if ($urandom_range(0, 7) == 0)  SW_SEL    = ~SW_SEL;
            ONE_TICK  = ($urandom_range(0, 2) == 0);
            ADJ_TICK  = ($urandom_range(0, 2) == 0);
            FAST_TICK = ($urandom_range(0, 1) == 0);
            cyc();
            chk_time("rnd", m_min, m_sec, m_mode == 1, m_mode == 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_control.md
STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 SHALL have parameter DEB_SAMPLES, default 3, meaning the number of consecutive equal FAST_TICK samples needed to accept a button level.
REQ-002 SHALL have port M_CLK, input, 1 bit: the single system clock; all logic is rising-edge.
REQ-003 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port ONE_TICK, input, 1 bit: one-cycle 1 Hz count strobe.
REQ-005 SHALL have port ADJ_TICK, input, 1 bit: one-cycle adjust-rate strobe.
REQ-006 SHALL have port FAST_TICK, input, 1 bit: one-cycle debounce sample strobe.
REQ-007 SHALL have ports BTN_PAUSE and BTN_RESET, input, 1 bit each: raw asynchronous push-buttons, active-high.
REQ-008 SHALL have port SW_ADJ, input, 1 bit: raw asynchronous adjust-mode switch.
REQ-009 SHALL have port SW_SEL, input, 1 bit: raw adjust field select; 0 = minutes, 1 = seconds.
REQ-010 SHALL have ports MIN_TENS, MIN_ONES, SEC_TENS and SEC_ONES, output, 4 bits each: registered BCD time digits.
REQ-011 SHALL have port RUNNING, output, 1 bit: high in state RUN.
REQ-012 SHALL have port ADJUSTING, output, 1 bit: high in state ADJ.

Function
REQ-013 SHALL pass BTN_PAUSE, BTN_RESET, SW_ADJ and SW_SEL each through a 2-flop synchronizer before any other use.
REQ-014 SHALL debounce each synchronized button: sample only on FAST_TICK; update the debounced level after DEB_SAMPLES consecutive identical samples.
REQ-015 SHALL generate one-cycle events pause_evt and clear_evt on each debounced 0->1 transition; release generates no event.
REQ-016 SHALL implement the FSM with states PAUSE (reset state), RUN and ADJ.
REQ-017 SHALL make these transitions, in priority order:
- synced SW_ADJ=1 -> ADJ from any state;
- ADJ with SW_ADJ=0 -> PAUSE;
- PAUSE with pause_evt -> RUN;
- RUN with pause_evt -> PAUSE.
REQ-018 SHALL change state on the edge after the event cycle (latency 1 clock from pause_evt to RUNNING).
REQ-019 SHALL, on clear_evt, set all digits to 0 and force PAUSE; if SW_ADJ=1, the state stays ADJ instead.
REQ-020 SHALL give clear_evt priority over any increment in the same cycle.
REQ-021 SHALL, in RUN on ONE_TICK, increment seconds:
- SEC_ONES 9 -> 0 with carry into SEC_TENS;
- SEC_TENS 5 -> 0 with carry into minutes, same digit rules;
- 59:59 -> 00:00 wrap with no flag.
REQ-022 SHALL, in ADJ on ADJ_TICK, increment only the field selected by SW_SEL, wrap 59 -> 00 within that field, and never carry into the other field.
REQ-023 SHALL ignore ONE_TICK in PAUSE and ADJ, and ignore ADJ_TICK in PAUSE and RUN.
REQ-024 SHALL, when ONE_TICK and pause_evt coincide in RUN, apply the increment and also transition to PAUSE.
REQ-025 SHALL keep ones digits in 0-9 and tens digits in 0-5 at all times, with no illegal BCD values reachable.

Reset
REQ-026 SHALL, when RST_N=0 at a rising M_CLK edge, set on that edge: all digits 0, state PAUSE, RUNNING=0, ADJUSTING=0, synchronizers and debounced levels 0, debounce counters 0.
REQ-027 SHALL give RST_N priority over all events, including mid-count and mid-debounce, with no pending event surviving reset.

Verification
REQ-028 SHALL cover: reset, BTN_PAUSE held for 4 FAST_TICKs -> RUNNING=1; 61 ONE_TICKs -> 01:01.
REQ-029 SHALL cover: adjust to 59:59, SW_ADJ=0, pause press, 1 ONE_TICK -> 00:00.
REQ-030 SHALL cover: BTN_PAUSE high for 1 FAST_TICK sample only -> no pause_evt, state unchanged.
REQ-031 SHALL cover: SW_ADJ=1, SW_SEL=1, time 00:58, 3 ADJ_TICKs plus interleaved ONE_TICKs -> 00:01, ADJUSTING=1.
REQ-032 SHALL cover: running at 12:34, clear press coinciding with ONE_TICK -> 00:00, RUNNING=0 one cycle after clear_evt.
REQ-033 SHALL cover: RST_N=0 for 1 cycle while running at 07:15 -> all outputs 0 on that edge; a subsequent ONE_TICK leaves 00:00.
